// File: rtl/paddle_bank_controller.sv
// Multi-team paddle controller: per-team button synchroniser, debounce and
// hold-to-accelerate FSM driving frame-rate clamped paddle positions.
module paddle_bank_controller #(
   parameter int NUM_TEAMS   = 2,
   parameter int POS_W       = 10,
   parameter int POS_MIN     = 0,
   parameter int POS_MAX     = 480,
   parameter int PADDLE_H    = 64,
   parameter int STEP_SLOW   = 1,
   parameter int STEP_FAST   = 4,
   parameter int HOLD_FRAMES = 30,
   parameter int DEB_TICKS   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clk_en,
   input  logic                       frame_tick,
   input  logic [NUM_TEAMS-1:0]       btn_up,
   input  logic [NUM_TEAMS-1:0]       btn_dn,
   output logic [NUM_TEAMS*POS_W-1:0] pos,
   output logic [NUM_TEAMS-1:0]       moving,
   output logic [NUM_TEAMS-1:0]       at_limit
);

   localparam int DEB_W  = $clog2(DEB_TICKS + 1);
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

   localparam logic [DEB_W-1:0]      DEB_LAST   = DEB_W'(DEB_TICKS - 1);
   localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
   localparam logic [HOLD_W-1:0]     HOLD_FULL  = HOLD_W'(HOLD_FRAMES);
   localparam logic [HOLD_W-1:0]     HOLD_ONE   = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]     HOLD_ZERO  = HOLD_W'(0);
   localparam logic [POS_W-1:0]      START_V    = POS_W'((POS_MIN + POS_MAX - PADDLE_H) / 2);
   localparam logic [POS_W-1:0]      LO_V       = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0]      HI_V       = POS_W'(POS_MAX - PADDLE_H);
   localparam logic signed [POS_W:0] LO_S       = (POS_W + 1)'(POS_MIN);
   localparam logic signed [POS_W:0] HI_S       = (POS_W + 1)'(POS_MAX - PADDLE_H);
   localparam logic signed [POS_W:0] SLOW_S     = (POS_W + 1)'(STEP_SLOW);
   localparam logic signed [POS_W:0] FAST_S     = (POS_W + 1)'(STEP_FAST);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SLOW  = 2'd1;
   localparam logic [1:0] ST_FAST  = 2'd2;

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DN   = 2'b10;

   for (genvar i = 0; i < NUM_TEAMS; i++) begin : g_team
      // bit 0 = up button, bit 1 = down button throughout this channel
      logic [1:0]        raw_s;
      logic [1:0]        sync1_r;
      logic [1:0]        sync2_r;
      logic [1:0]        deb_r;
      logic [DEB_W-1:0]  cnt_r [2];
      logic [1:0]        dir_s;
      logic [1:0]        state_r;
      logic [1:0]        state_nx_s;
      logic [HOLD_W-1:0] hold_r;
      logic [HOLD_W-1:0] hold_nx_s;
      logic [1:0]        last_dir_r;
      logic [1:0]        dir_nx_s;
      logic              move_s;
      logic              fast_s;
      logic signed [POS_W:0] mag_s;
      logic signed [POS_W:0] delta_s;
      logic signed [POS_W:0] sum_s;
      logic [POS_W-1:0]  pos_nx_s;
      logic [POS_W-1:0]  pos_r;
      logic              moving_r;
      logic              at_limit_r;

      assign raw_s = {btn_dn[i], btn_up[i]};

      // Two-flop synchroniser, runs on every clock regardless of clk_en
      always_ff @(posedge clk) begin
         if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
         end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
         end
      end

      // Debounce: a button flips only after DEB_TICKS consecutive differing enabled samples
      always_ff @(posedge clk) begin
         if (rst) begin
            deb_r    <= 2'b00;
            cnt_r[0] <= {DEB_W{1'b0}};
            cnt_r[1] <= {DEB_W{1'b0}};
         end else if (clk_en) begin
            for (int b = 0; b < 2; b++) begin
               if (sync2_r[b] != deb_r[b]) begin
                  if (cnt_r[b] == DEB_LAST) begin
                     deb_r[b] <= sync2_r[b];
                     cnt_r[b] <= {DEB_W{1'b0}};
                  end else begin
                     cnt_r[b] <= cnt_r[b] + DEB_W'(1);
                  end
               end else begin
                  cnt_r[b] <= {DEB_W{1'b0}};
               end
            end
         end
      end

      // Direction decode: both or neither pressed means no request
      always_comb begin
         if (deb_r == 2'b01) begin
            dir_s = DIR_UP;
         end else if (deb_r == 2'b10) begin
            dir_s = DIR_DN;
         end else begin
            dir_s = DIR_NONE;
         end
      end

      // Next-state, hold counter and clamped next position for one frame
      always_comb begin
         state_nx_s = state_r;
         hold_nx_s  = hold_r;
         dir_nx_s   = last_dir_r;
         move_s     = 1'b0;
         fast_s     = 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (dir_s != DIR_NONE) begin
                  state_nx_s = ST_SLOW;
                  hold_nx_s  = HOLD_ONE;
                  dir_nx_s   = dir_s;
                  move_s     = 1'b1;
               end else begin
                  hold_nx_s  = HOLD_ZERO;
               end
            end
            ST_SLOW: begin
               if (dir_s == DIR_NONE) begin
                  state_nx_s = ST_IDLE;
                  hold_nx_s  = HOLD_ZERO;
               end else if (dir_s == last_dir_r) begin
                  move_s = 1'b1;
                  if (hold_r >= HOLD_LAST) begin
                     hold_nx_s  = HOLD_FULL;
                     state_nx_s = ST_FAST;
                  end else begin
                     hold_nx_s  = hold_r + HOLD_ONE;
                  end
               end else begin
                  hold_nx_s = HOLD_ONE;
                  dir_nx_s  = dir_s;
                  move_s    = 1'b1;
               end
            end
            ST_FAST: begin
               if (dir_s == DIR_NONE) begin
                  state_nx_s = ST_IDLE;
                  hold_nx_s  = HOLD_ZERO;
               end else if (dir_s == last_dir_r) begin
                  move_s = 1'b1;
                  fast_s = 1'b1;
               end else begin
                  // reversal drops back to slow speed, first step already in the new direction
                  state_nx_s = ST_SLOW;
                  hold_nx_s  = HOLD_ONE;
                  dir_nx_s   = dir_s;
                  move_s     = 1'b1;
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
               hold_nx_s  = HOLD_ZERO;
               dir_nx_s   = DIR_NONE;
            end
         endcase

         if (fast_s) begin
            mag_s = FAST_S;
         end else begin
            mag_s = SLOW_S;
         end

         if (!move_s) begin
            delta_s = (POS_W + 1)'(0);
         end else if (dir_nx_s == DIR_UP) begin
            delta_s = -mag_s;
         end else begin
            delta_s = mag_s;
         end

         sum_s = $signed({1'b0, pos_r}) + delta_s;

         if (sum_s < LO_S) begin
            pos_nx_s = LO_V;
         end else if (sum_s > HI_S) begin
            pos_nx_s = HI_V;
         end else begin
            pos_nx_s = sum_s[POS_W-1:0];
         end
      end

      // Channel state and outputs advance only on an enabled frame tick
      always_ff @(posedge clk) begin
         if (rst) begin
            state_r    <= ST_IDLE;
            hold_r     <= HOLD_ZERO;
            last_dir_r <= DIR_NONE;
            pos_r      <= START_V;
            moving_r   <= 1'b0;
            at_limit_r <= 1'b0;
         end else if (clk_en && frame_tick) begin
            state_r    <= state_nx_s;
            hold_r     <= hold_nx_s;
            last_dir_r <= dir_nx_s;
            pos_r      <= pos_nx_s;
            moving_r   <= (state_nx_s != ST_IDLE);
            at_limit_r <= (pos_nx_s == LO_V) || (pos_nx_s == HI_V);
         end
      end

      assign pos[i*POS_W +: POS_W] = pos_r;
      assign moving[i]             = moving_r;
      assign at_limit[i]           = at_limit_r;
   end

endmodule
